// File: rtl/idu_pipe.sv
// idu_pipe: RV32I decode stage between IFU and EXU.
// Registered decode with a two-entry skid buffer, flush and illegal flagging.
module idu_pipe #(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [XLEN-1:0] out_imm,
    output logic [5:0]      out_inst_type,
    output logic [3:0]      out_alu_op,
    output logic            out_alusrc1,
    output logic            out_alusrc2,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_memtoreg,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_illegal
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [5:0] T_I = 6'b100000;
    localparam logic [5:0] T_R = 6'b010000;
    localparam logic [5:0] T_S = 6'b001000;
    localparam logic [5:0] T_B = 6'b000100;
    localparam logic [5:0] T_U = 6'b000010;
    localparam logic [5:0] T_J = 6'b000001;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        logic [5:0]      inst_type;
        logic [3:0]      alu_op;
        logic            alusrc1;
        logic            alusrc2;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            memtoreg;
        logic            branch;
        logic            jump;
        logic            illegal;
    } ent_t;

    // alt selects SUB/SRA over ADD/SRL where funct7[5] applies
    function automatic logic [3:0] alu_sel(input logic [2:0] f, input logic alt);
        case (f)
            3'b000:  alu_sel = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_sel = ALU_SLL;
            3'b010:  alu_sel = ALU_SLT;
            3'b011:  alu_sel = ALU_SLTU;
            3'b100:  alu_sel = ALU_XOR;
            3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc   = in_inst[6:0];
    assign f3    = in_inst[14:12];
    assign f7    = in_inst[31:25];
    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                  in_inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                  in_inst[30:21], 1'b0}));

    ent_t dec;
    logic ok;

    // Combinational decode of the offered instruction
    always_comb begin
        dec        = '0;
        ok         = 1'b0;
        dec.funct3 = f3;
        case (opc)
            OPC_OP: begin
                ok = (f7 == 7'b0000000) ||
                     (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                dec.inst_type = T_R;
                dec.rs1       = in_inst[19:15];
                dec.rs2       = in_inst[24:20];
                dec.rd        = in_inst[11:7];
                dec.alu_op    = alu_sel(f3, f7[5]);
                dec.reg_write = 1'b1;
            end
            OPC_OPIMM: begin
                if (f3 == 3'b001)
                    ok = (f7 == 7'b0000000);
                else if (f3 == 3'b101)
                    ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else
                    ok = 1'b1;
                dec.inst_type = T_I;
                dec.rs1       = in_inst[19:15];
                dec.rd        = in_inst[11:7];
                dec.imm       = imm_i;
                dec.alu_op    = alu_sel(f3, (f3 == 3'b101) && f7[5]);
                dec.alusrc2   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                dec.inst_type = T_I;
                dec.rs1       = in_inst[19:15];
                dec.rd        = in_inst[11:7];
                dec.imm       = imm_i;
                dec.alu_op    = ALU_ADD;
                dec.alusrc2   = 1'b1;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.memtoreg  = 1'b1;
            end
            OPC_STORE: begin
                ok = !f3[2] && (f3 != 3'b011);
                dec.inst_type = T_S;
                dec.rs1       = in_inst[19:15];
                dec.rs2       = in_inst[24:20];
                dec.imm       = imm_s;
                dec.alu_op    = ALU_ADD;
                dec.alusrc2   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                ok = (f3 != 3'b010) && (f3 != 3'b011);
                dec.inst_type = T_B;
                dec.rs1       = in_inst[19:15];
                dec.rs2       = in_inst[24:20];
                dec.imm       = imm_b;
                dec.branch    = 1'b1;
                if (!f3[2])
                    dec.alu_op = ALU_SUB;
                else if (!f3[1])
                    dec.alu_op = ALU_SLT;
                else
                    dec.alu_op = ALU_SLTU;
            end
            OPC_LUI: begin
                ok = 1'b1;
                dec.inst_type = T_U;
                dec.rd        = in_inst[11:7];
                dec.imm       = imm_u;
                dec.alu_op    = ALU_PASSB;
                dec.alusrc2   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                ok = 1'b1;
                dec.inst_type = T_U;
                dec.rd        = in_inst[11:7];
                dec.imm       = imm_u;
                dec.alu_op    = ALU_ADD;
                dec.alusrc1   = 1'b1;
                dec.alusrc2   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                ok = 1'b1;
                dec.inst_type = T_J;
                dec.rd        = in_inst[11:7];
                dec.imm       = imm_j;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_JALR: begin
                ok = (f3 == 3'b000);
                dec.inst_type = T_I;
                dec.rs1       = in_inst[19:15];
                dec.rd        = in_inst[11:7];
                dec.imm       = imm_i;
                dec.alu_op    = ALU_ADD;
                dec.alusrc2   = 1'b1;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.pc = in_pc;
    end

    ent_t main_q, main_d, skid_q, skid_d;
    logic main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic accept, consume;

    assign in_ready = SKID_EN ? !skid_v_q : (!main_v_q || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign consume  = main_v_q && out_ready;

    // Main/skid next state; skid only fills while main is stalled
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (consume) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end else if (accept) begin
                main_d = dec;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (!main_v_q) begin
            if (accept) begin
                main_d   = dec;
                main_v_d = 1'b1;
            end
        end else if (accept && SKID_EN) begin
            skid_d   = dec;
            skid_v_d = 1'b1;
        end
    end

    // Buffer registers, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign out_valid     = main_v_q;
    assign out_pc        = main_q.pc;
    assign out_rs1       = main_q.rs1;
    assign out_rs2       = main_q.rs2;
    assign out_rd        = main_q.rd;
    assign out_funct3    = main_q.funct3;
    assign out_imm       = main_q.imm;
    assign out_inst_type = main_q.inst_type;
    assign out_alu_op    = main_q.alu_op;
    assign out_alusrc1   = main_q.alusrc1;
    assign out_alusrc2   = main_q.alusrc2;
    assign out_reg_write = main_q.reg_write;
    assign out_mem_read  = main_q.mem_read;
    assign out_mem_write = main_q.mem_write;
    assign out_memtoreg  = main_q.memtoreg;
    assign out_branch    = main_q.branch;
    assign out_jump      = main_q.jump;
    assign out_illegal   = main_q.illegal;
endmodule
